pci_init32: RTL and testbench
=============================

PCI_INIT32 -- requirements
Module: pci_init32

Interface
REQ-001 The block SHALL use one clock and one reset: the reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  PCI clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  local request strobe.
- cmd_ready  out  1  high when idle and able to accept a request.
- cmd_wr  in  1  1 = memory write (C/BE 0111), 0 = memory read (C/BE 0110).
- cmd_addr  in  32  dword address; bits [1:0] are driven 00.
- cmd_wdata  in  32  write data.
- cmd_be  in  4  active-high byte enables; inverted onto c_be_.
- done  out  1  one-cycle completion pulse.
- status  out  3  completion code, valid with done: 000 ok, 001 master abort, 010 target abort, 011 retry, 100 timeout.
- rdata  out  32  read data, valid with done when status=000.
- req_, frame_o, irdy_o  out  1 each  bus request and initiator strobes.
- ctl_oe  out  1  output enable for frame_o and irdy_o.
- ad_out / ad_oe  out  32 / 1  AD drive value and its enable.
- cbe_out / cbe_oe  out  4 / 1  C/BE# drive value and its enable.
- ad_in  in  32  sampled AD bus.
- gnt_, frame_i, irdy_i, trdy_, devsel_, stop_  in  1 each  sampled bus signals.

Function
REQ-003 The state machine SHALL have states IDLE, REQ, ADDR, DATA, TURN.
REQ-004 IDLE: cmd_ready=1. On cmd_valid=1, latch all cmd_* fields, drive req_=0 next cycle, go to REQ. While not IDLE, cmd_valid is ignored.
REQ-005 REQ: go to ADDR only when gnt_=0, frame_i=1 and irdy_i=1 are all sampled in the same cycle; otherwise hold req_=0.
REQ-006 ADDR (exactly 1 cycle): drive frame_o=0, ctl_oe=1, ad_oe=1, ad_out=addr, cbe_oe=1, cbe_out=command; release req_=1.
REQ-007 DATA entry: drive frame_o=1 (single beat), irdy_o=0, cbe_out=~be.
- Write: ad_oe=1, ad_out=wdata.
- Read: ad_oe=0 from the first DATA cycle.
REQ-008 A 5-bit wait counter SHALL clear on DATA entry and increment on every DATA cycle without termination.
REQ-009 DATA termination priority (highest first), each going to TURN:
- (a) trdy_=0 and devsel_=0: status 000; on read, rdata <= ad_in in the same edge.
- (b) stop_=0, trdy_=1, devsel_=0: status 011.
- (c) stop_=0, devsel_=1 after devsel_ was seen asserted: status 010.
- (d) devsel_ still 1 when counter=5: status 001.
- (e) counter=16: status 100.
REQ-010 TURN (1 cycle): drive irdy_o=1 with ctl_oe=1, ad_oe=0, cbe_oe=0, and pulse done=1. Next cycle: ctl_oe=0, return to IDLE, cmd_ready=1.
REQ-011 Minimum transaction SHALL be 5 cycles from cmd_valid to done when gnt_ is already asserted and the target responds fast.
REQ-012 trdy_=0 and stop_=0 sampled in the same cycle SHALL complete as status 000 (a disconnect with data).

Reset
REQ-013 When rst=1 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-transaction.
REQ-014 Reset values SHALL be: req_=1, frame_o=1, irdy_o=1, all *_oe=0, done=0, status=000, rdata=0, cmd_ready=1, counter=0.
REQ-015 Reset mid-transaction SHALL produce no done pulse.

Configuration
REQ-016 The macro PCI_INIT_RETRY_EN SHALL control automatic retry.
- Defined: a retry termination SHALL return to REQ with latched fields unchanged, up to 7 re-issues, without pulsing done. The 8th retry SHALL complete with status 011.
- Undefined: the first retry SHALL complete immediately with status 011, and no retry counter is instantiated.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Write addr 0x0000_1004, data 0xDEADBEEF, be 1111; gnt_ low; target devsel_/trdy_ on DATA cycle 1 -> ADDR shows AD=0x0000_1004, C/BE=0111; DATA shows AD=0xDEADBEEF, C/BE=0000; done with status 000 five cycles after cmd_valid.
- Read addr 0x10; target returns 0x12345678 after 3 wait cycles -> ad_oe=0 throughout DATA; rdata=0x12345678; status 000.
- No devsel_ -> done with status 001 after DATA counter reaches 5; frame_o/irdy_o released via TURN.
- Target asserts devsel_, then stop_ with trdy_=1 -> retry handling:
  - Macro undefined: status 011.
  - Macro defined: re-issued; 8th retry completes with status 011; a success on the 3rd attempt completes with status 000 and exactly one done pulse.
- gnt_ held high 20 cycles -> req_ stays 0 with no ADDR phase; then gnt_ low with frame_i low -> stays in REQ until frame_i=1.
- rst asserted during DATA -> next cycle all reset values hold, no done pulse, and a new command is accepted normally.

Source files
------------

// File: rtl/pci_init32.sv
// pci_init32: single-beat 32-bit PCI memory read/write initiator.
// Define PCI_INIT_RETRY_EN to re-issue retried transactions automatically (up to 7 times).
module pci_init32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        done,
    output logic [2:0]  status,
    output logic [31:0] rdata,
    output logic        req_,
    output logic        frame_o,
    output logic        irdy_o,
    output logic        ctl_oe,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic [3:0]  cbe_out,
    output logic        cbe_oe,
    input  logic [31:0] ad_in,
    input  logic        gnt_,
    input  logic        frame_i,
    input  logic        irdy_i,
    input  logic        trdy_,
    input  logic        devsel_,
    input  logic        stop_
);
    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_t;

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic [2:0]  status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef PCI_INIT_RETRY_EN
    logic [2:0]  retry_q, retry_d;
`endif

    logic term_ok, term_retry, term_tabort, term_mabort, term_tout;

    // Data-phase terminations, listed in priority order.
    assign term_ok     = !trdy_ && !devsel_;
    assign term_retry  = !stop_ && trdy_ && !devsel_;
    assign term_tabort = !stop_ && devsel_ && seen_q;
    assign term_mabort = devsel_ && !seen_q && (cnt_q == 5'd5);
    assign term_tout   = (cnt_q == 5'd16);

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        status_d  = status_q;
        rdata_d   = rdata_q;
`ifdef PCI_INIT_RETRY_EN
        retry_d   = retry_q;
`endif
        cmd_ready = 1'b0;
        done      = 1'b0;
        req_      = 1'b1;
        frame_o   = 1'b1;
        irdy_o    = 1'b1;
        ctl_oe    = 1'b0;
        ad_out    = '0;
        ad_oe     = 1'b0;
        cbe_out   = '0;
        cbe_oe    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    be_d    = cmd_be;
`ifdef PCI_INIT_RETRY_EN
                    retry_d = '0;
`endif
                    state_d = REQ;
                end
            end
            REQ: begin
                req_ = 1'b0;
                if (!gnt_ && frame_i && irdy_i) state_d = ADDR;
            end
            ADDR: begin
                frame_o = 1'b0;
                ctl_oe  = 1'b1;
                ad_oe   = 1'b1;
                ad_out  = addr_q;
                cbe_oe  = 1'b1;
                cbe_out = wr_q ? CMD_MEM_WR : CMD_MEM_RD;
                cnt_d   = '0;
                seen_d  = 1'b0;
                state_d = DATA;
            end
            DATA: begin
                irdy_o  = 1'b0;
                ctl_oe  = 1'b1;
                ad_oe   = wr_q;
                ad_out  = wdata_q;
                cbe_oe  = 1'b1;
                cbe_out = ~be_q;
                if (term_ok) begin
                    status_d = 3'b000;
                    if (!wr_q) rdata_d = ad_in;
                    state_d  = TURN;
                end else if (term_retry) begin
`ifdef PCI_INIT_RETRY_EN
                    if (retry_q == 3'd7) begin
                        status_d = 3'b011;
                        state_d  = TURN;
                    end else begin
                        retry_d = retry_q + 3'd1;
                        state_d = REQ;
                    end
`else
                    status_d = 3'b011;
                    state_d  = TURN;
`endif
                end else if (term_tabort) begin
                    status_d = 3'b010;
                    state_d  = TURN;
                end else if (term_mabort) begin
                    status_d = 3'b001;
                    state_d  = TURN;
                end else if (term_tout) begin
                    status_d = 3'b100;
                    state_d  = TURN;
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    seen_d = seen_q || !devsel_;
                end
            end
            TURN: begin
                ctl_oe  = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            cnt_q    <= '0;
            seen_q   <= 1'b0;
            status_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef PCI_INIT_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) retry_q <= '0;
        else     retry_q <= retry_d;
    end
`endif

    assign status = status_q;
    assign rdata  = rdata_q;
endmodule

// File: tb/tb_pci_init32.sv
// Self-checking bench for pci_init32: procedural transaction model plus directed and random traffic.
// Honours PCI_INIT_RETRY_EN the same way the design does.
module tb_pci_init32;
    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, cmd_wr, done;
    logic [31:0] cmd_addr, cmd_wdata, rdata, ad_out, ad_in;
    logic [3:0]  cmd_be, cbe_out;
    logic [2:0]  status;
    logic        req_, frame_o, irdy_o, ctl_oe, ad_oe, cbe_oe;
    logic        gnt_, frame_i, irdy_i, trdy_, devsel_, stop_;

    always #5 clk = ~clk;

    pci_init32 dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .done(done), .status(status), .rdata(rdata),
        .req_(req_), .frame_o(frame_o), .irdy_o(irdy_o), .ctl_oe(ctl_oe),
        .ad_out(ad_out), .ad_oe(ad_oe), .cbe_out(cbe_out), .cbe_oe(cbe_oe),
        .ad_in(ad_in), .gnt_(gnt_), .frame_i(frame_i), .irdy_i(irdy_i),
        .trdy_(trdy_), .devsel_(devsel_), .stop_(stop_)
    );

`ifdef PCI_INIT_RETRY_EN
    localparam int unsigned MAX_REISSUE = 7;
`else
    localparam int unsigned MAX_REISSUE = 0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          mv = 1'b0;
    logic        e_ready, e_req, e_frame, e_irdy, e_ctl, e_ad_oe, e_cbe_oe, e_done;
    logic [31:0] e_ad;
    logic [3:0]  e_cbe;
    logic [2:0]  m_status = '0;
    logic [31:0] m_rdata = '0;

    task automatic expect_outs(input logic ready, input logic rq, input logic fr, input logic ir,
                               input logic ctl, input logic adoe, input logic [31:0] adv,
                               input logic cbeoe, input logic [3:0] cbev, input logic dn);
        e_ready = ready; e_req = rq; e_frame = fr; e_irdy = ir; e_ctl = ctl;
        e_ad_oe = adoe; e_ad = adv; e_cbe_oe = cbeoe; e_cbe = cbev; e_done = dn;
    endtask

    task automatic set_exp_idle();
        expect_outs(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic m_step(output bit r);
        @(posedge clk);
        r = (rst === 1'b1);
        if (r) begin
            mv = 1'b1;
            m_status = '0;
            m_rdata = '0;
            set_exp_idle();
        end
    endtask

    task automatic model_txn();
        bit          r;
        logic        wr;
        logic [31:0] a, w;
        logic [3:0]  be;
        int unsigned tries, n;
        bit          seen;
        int          code;
        set_exp_idle();
        m_step(r);
        if (r || cmd_valid !== 1'b1) return;
        wr = cmd_wr; a = cmd_addr; w = cmd_wdata; be = cmd_be;
        tries = 0;
        forever begin
            expect_outs(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
            do begin
                m_step(r);
                if (r) return;
            end while (!(gnt_ === 1'b0 && frame_i === 1'b1 && irdy_i === 1'b1));
            expect_outs(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, a, 1'b1, wr ? 4'b0111 : 4'b0110, 1'b0);
            m_step(r);
            if (r) return;
            expect_outs(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, wr, w, 1'b1, ~be, 1'b0);
            n = 0; seen = 1'b0; code = -1;
            while (code < 0) begin
                m_step(r);
                if (r) return;
                if (!trdy_ && !devsel_) begin
                    code = 0;
                    if (!wr) m_rdata = ad_in;
                end
                else if (!stop_ && trdy_ && !devsel_) code = 3;
                else if (!stop_ && devsel_ && seen)   code = 2;
                else if (devsel_ && !seen && n == 5)  code = 1;
                else if (n == 16)                      code = 4;
                else begin
                    seen = seen || (devsel_ == 1'b0);
                    n++;
                end
            end
            if (code == 3 && tries < MAX_REISSUE) begin
                tries++;
                continue;
            end
            m_status = code[2:0];
            expect_outs(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
            m_step(r);
            return;
        end
    endtask

    initial begin
        set_exp_idle();
        forever model_txn();
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("cmd_ready", cmd_ready, e_ready);
            chk("req_", req_, e_req);
            chk("frame_o", frame_o, e_frame);
            chk("irdy_o", irdy_o, e_irdy);
            chk("ctl_oe", ctl_oe, e_ctl);
            chk("ad_oe", ad_oe, e_ad_oe);
            chk("cbe_oe", cbe_oe, e_cbe_oe);
            chk("done", done, e_done);
            chk("status", status, m_status);
            chk("rdata", rdata, m_rdata);
            if (e_ad_oe) chk("ad_out", ad_out, e_ad);
            if (e_cbe_oe) chk("cbe_out", cbe_out, e_cbe);
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_set(input logic g, input logic dv, input logic tr, input logic st);
        gnt_ = g; frame_i = 1'b1; irdy_i = 1'b1; devsel_ = dv; trdy_ = tr; stop_ = st;
    endtask

    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        cmd_wr = wr; cmd_addr = a; cmd_wdata = w; cmd_be = be; cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned maxc, output int unsigned n);
        n = 0;
        while (done !== 1'b1 && n < maxc) begin
            cyc();
            n++;
        end
        chk("done_wait", done, 1'b1);
    endtask

    task automatic chk_reset_vals();
        chk("rv_req_", req_, 1'b1);       chk("rv_frame_o", frame_o, 1'b1);
        chk("rv_irdy_o", irdy_o, 1'b1);   chk("rv_ctl_oe", ctl_oe, 1'b0);
        chk("rv_ad_oe", ad_oe, 1'b0);     chk("rv_cbe_oe", cbe_oe, 1'b0);
        chk("rv_done", done, 1'b0);       chk("rv_status", status, 3'b000);
        chk("rv_rdata", rdata, 32'h0);    chk("rv_cmd_ready", cmd_ready, 1'b1);
    endtask

    task automatic rand_inputs(input bit slow);
        gnt_    = ($urandom_range(9) < 3);
        frame_i = ($urandom_range(9) != 0);
        irdy_i  = ($urandom_range(9) != 0);
        devsel_ = 1'($urandom_range(1));
        trdy_   = slow ? 1'b1 : ($urandom_range(9) >= 3);
        stop_   = slow ? ($urandom_range(39) != 0) : ($urandom_range(9) >= 2);
        cmd_valid = 1'($urandom_range(1));
        cmd_wr    = 1'($urandom_range(1));
        cmd_addr  = $urandom() & 32'hFFFF_FFFC;
        cmd_wdata = $urandom();
        cmd_be    = 4'($urandom_range(15));
        ad_in     = $urandom();
        rst       = ($urandom_range(199) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned n, dc0;
`ifdef PCI_INIT_RETRY_EN
        int unsigned addr_seen;
`endif
        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        ad_in = '0;
        bus_set(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(); cyc();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // Fast write: done in the fifth cycle counting the cmd_valid cycle.
        bus_set(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk); chk("w_req_low", req_, 1'b0);
        cyc(); @(negedge clk);
        chk("w_addr_ad", ad_out, 32'h0000_1004); chk("w_addr_cbe", cbe_out, 4'b0111);
        chk("w_addr_frame", frame_o, 1'b0);
        cyc(); @(negedge clk);
        chk("w_data_ad", ad_out, 32'hDEAD_BEEF); chk("w_data_cbe", cbe_out, 4'b0000);
        chk("w_data_frame", frame_o, 1'b1);      chk("w_data_irdy", irdy_o, 1'b0);
        cyc(); @(negedge clk);
        chk("w_done", done, 1'b1); chk("w_status", status, 3'b000);
        cyc();

        // Read with three wait states.
        bus_set(1'b0, 1'b1, 1'b1, 1'b1);
        send(1'b0, 32'h0000_0010, 32'h0, 4'hF);
        cyc(); cyc();
        devsel_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("r_ad_oe", ad_oe, 1'b0);
            cyc();
        end
        trdy_ = 1'b0; ad_in = 32'h1234_5678;
        @(negedge clk); chk("r_ad_oe", ad_oe, 1'b0);
        cyc(); @(negedge clk);
        chk("r_done", done, 1'b1); chk("r_status", status, 3'b000); chk("r_rdata", rdata, 32'h1234_5678);
        ad_in = '0; bus_set(1'b0, 1'b1, 1'b1, 1'b1);
        cyc();

        // No DEVSEL#: master abort once the counter reaches 5.
        send(1'b1, 32'h0000_2000, 32'h55, 4'h3);
        wait_done(40, n);
        chk("ma_cycles", n, 8);
        @(negedge clk);
        chk("ma_status", status, 3'b001); chk("ma_frame", frame_o, 1'b1);
        chk("ma_irdy", irdy_o, 1'b1);     chk("ma_ctl_oe", ctl_oe, 1'b1);
        cyc();

        // Retry on every attempt.
        dc0 = done_cnt;
        bus_set(1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 32'h0000_3000, 32'hA5A5, 4'hF);
        wait_done(100, n);
        chk("retry_cycles", n, 3 * (MAX_REISSUE + 1));
        @(negedge clk); chk("retry_status", status, 3'b011);
        bus_set(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(); cyc();
        chk("retry_pulses", done_cnt - dc0, 1);

`ifdef PCI_INIT_RETRY_EN
        // Two retries, then success on the third attempt.
        dc0 = done_cnt; addr_seen = 0;
        bus_set(1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 32'h0000_0040, 32'h0, 4'hF);
        ad_in = 32'hCAFE_0003;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_o === 1'b0) addr_seen++;
            if (addr_seen >= 3) begin trdy_ = 1'b0; stop_ = 1'b1; end
            if (done === 1'b1) break;
            cyc();
        end
        chk("rs3_done", done, 1'b1); chk("rs3_status", status, 3'b000);
        chk("rs3_rdata", rdata, 32'hCAFE_0003); chk("rs3_attempts", addr_seen, 3);
        ad_in = '0; bus_set(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(); cyc();
        chk("rs3_pulses", done_cnt - dc0, 1);
`endif

        // GNT# withheld, then bus busy (FRAME# asserted).
        bus_set(1'b1, 1'b1, 1'b1, 1'b1);
        send(1'b1, 32'h0000_5000, 32'h1, 4'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); chk("g_req_held", req_, 1'b0); chk("g_no_addr", frame_o, 1'b1);
            cyc();
        end
        gnt_ = 1'b0; frame_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("g_busy_req", req_, 1'b0); chk("g_busy_frame", frame_o, 1'b1);
            cyc();
        end
        frame_i = 1'b1;
        cyc(); @(negedge clk); chk("g_addr", frame_o, 1'b0);
        devsel_ = 1'b0; trdy_ = 1'b0;
        wait_done(10, n);
        chk("g_status", status, 3'b000);
        cyc();

        // Reset in the middle of a data phase.
        dc0 = done_cnt;
        bus_set(1'b0, 1'b1, 1'b1, 1'b1);
        send(1'b0, 32'h0000_6000, 32'h0, 4'hF);
        cyc(); cyc(); cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        @(negedge clk); chk_reset_vals();
        repeat (3) cyc();
        chk("mid_no_done", done_cnt - dc0, 0);
        bus_set(1'b0, 1'b0, 1'b0, 1'b1);
        send(1'b1, 32'h0000_7000, 32'h77, 4'hF);
        wait_done(10, n);
        chk("mid_new_cycles", n, 3); chk("mid_new_status", status, 3'b000);
        cyc();

        // DEVSEL# claimed but no TRDY#/STOP#: timeout at counter 16.
        bus_set(1'b0, 1'b0, 1'b1, 1'b1);
        send(1'b1, 32'h0000_8000, 32'h88, 4'hF);
        wait_done(40, n);
        chk("to_cycles", n, 19);
        @(negedge clk); chk("to_status", status, 3'b100);
        cyc();

        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < 200; i++) begin
                rand_inputs(blk % 3 == 2);
                cyc();
            end
        end
        rst = 1'b0; cmd_valid = 1'b0;
        bus_set(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (30) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
